// File: rtl/div_avalon_scheduler.sv
// -----------------------------------------------------------------------------
// div_avalon_scheduler
//
// Avalon-MM master that shares one div_avalon integer divider between N
// client requesters. Pending requests are arbitrated round-robin. For the
// winner, the block runs the divider register sequence: dividend, divisor,
// start, wait for irq, read quotient, read remainder, clear irq. The result
// is then returned to that client with a one-cycle done pulse.
//
// Optional feature: define DIVZERO_BYPASS_EN to resolve zero-divisor jobs
// locally. Such a job causes no bus traffic; its result is quotient = all
// ones and remainder = dividend, flagged on o_divzero.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_req[N]                  per-client request, held until own done
//   i_dividend_flat[N*W]      client i dividend at [i*W +: W]
//   i_divisor_flat[N*W]       client i divisor  at [i*W +: W]
//   o_done[N]                 one-cycle completion pulse to served client
//   o_quotient, o_remainder   result, held until the next done
//   o_resp_id                 index of served client, held until next done
//   o_busy                    high from grant through the done cycle
//   o_divzero                 (DIVZERO_BYPASS_EN only) bypassed job flag
//   o_avm_*                   divider Avalon-MM master signals
//   i_avm_readdata            divider read data, one wait state
//   i_div_irq                 divider completion interrupt
// -----------------------------------------------------------------------------
module div_avalon_scheduler #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = 2
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_dividend_flat,
  input  logic [N*W-1:0] i_divisor_flat,
  output logic [N-1:0]   o_done,
  output logic [W-1:0]   o_quotient,
  output logic [W-1:0]   o_remainder,
  output logic [IDW-1:0] o_resp_id,
  output logic           o_busy,
`ifdef DIVZERO_BYPASS_EN
  output logic           o_divzero,
`endif
  output logic           o_avm_chipselect,
  output logic           o_avm_read,
  output logic           o_avm_write,
  output logic [2:0]     o_avm_address,
  output logic [W-1:0]   o_avm_writedata,
  input  logic [W-1:0]   i_avm_readdata,
  input  logic           i_div_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DVND, S_WR_DVSR, S_WR_START, S_WAIT_IRQ,
    S_RD_QUOT, S_RD_QUOT_W, S_RD_REM, S_RD_REM_W, S_CLR_IRQ, S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_qTmp;
  logic [W-1:0]   r_rTmp;
  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_cand;
  logic [W-1:0]   w_curDvnd;
  logic [W-1:0]   w_curDvsr;
  logic           w_rd;
  logic           w_wr;
  logic [2:0]     w_addr;
`ifdef DIVZERO_BYPASS_EN
  logic           w_bypass;
  logic [W-1:0]   w_grantDvnd;
  logic [W-1:0]   w_grantDvsr;

  assign w_grantDvnd = i_dividend_flat[int'(w_grant)*W +: W];
  assign w_grantDvsr = i_divisor_flat[int'(w_grant)*W +: W];
`endif

  // Operands of the client being served, read live from the flat buses
  assign w_curDvnd = i_dividend_flat[int'(r_id)*W +: W];
  assign w_curDvsr = i_divisor_flat[int'(r_id)*W +: W];

  // Round-robin search: first pending request after the last winner
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Next-state logic; arbitration happens only in IDLE
  always_comb begin
    w_next = r_state;
`ifdef DIVZERO_BYPASS_EN
    w_bypass = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
`ifdef DIVZERO_BYPASS_EN
          if (w_grantDvsr == '0) begin
            w_bypass = 1'b1;
            w_next   = S_DONE;
          end else begin
            w_next = S_WR_DVND;
          end
`else
          w_next = S_WR_DVND;
`endif
        end
      end
      S_WR_DVND:   w_next = S_WR_DVSR;
      S_WR_DVSR:   w_next = S_WR_START;
      S_WR_START:  w_next = S_WAIT_IRQ;
      S_WAIT_IRQ:  if (i_div_irq) w_next = S_RD_QUOT;
      S_RD_QUOT:   w_next = S_RD_QUOT_W;
      S_RD_QUOT_W: w_next = S_RD_REM;
      S_RD_REM:    w_next = S_RD_REM_W;
      S_RD_REM_W:  w_next = S_CLR_IRQ;
      S_CLR_IRQ:   w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Bus strobes are decoded from the upcoming state so they can be
  // registered and line up exactly with the state that owns the access
  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_addr = 3'd0;
    case (w_next)
      S_WR_DVND:  begin w_wr = 1'b1; w_addr = 3'd0; end
      S_WR_DVSR:  begin w_wr = 1'b1; w_addr = 3'd1; end
      S_WR_START: begin w_wr = 1'b1; w_addr = 3'd2; end
      S_RD_QUOT:  begin w_rd = 1'b1; w_addr = 3'd3; end
      S_RD_REM:   begin w_rd = 1'b1; w_addr = 3'd4; end
      S_CLR_IRQ:  begin w_wr = 1'b1; w_addr = 3'd6; end
      default:    ;
    endcase
  end

  // Write data is taken from the flat buses in the write cycle itself
  always_comb begin
    o_avm_writedata = '0;
    case (r_state)
      S_WR_DVND: o_avm_writedata = w_curDvnd;
      S_WR_DVSR: o_avm_writedata = w_curDvsr;
      default:   o_avm_writedata = '0;
    endcase
  end

  // State, pointer, captured read data and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_ptr            <= IDW'(N-1);
      r_id             <= '0;
      r_qTmp           <= '0;
      r_rTmp           <= '0;
      o_done           <= '0;
      o_quotient       <= '0;
      o_remainder      <= '0;
      o_resp_id        <= '0;
      o_busy           <= 1'b0;
      o_avm_chipselect <= 1'b0;
      o_avm_read       <= 1'b0;
      o_avm_write      <= 1'b0;
      o_avm_address    <= 3'd0;
`ifdef DIVZERO_BYPASS_EN
      o_divzero        <= 1'b0;
`endif
    end else begin
      r_state          <= w_next;
      o_avm_chipselect <= w_rd | w_wr;
      o_avm_read       <= w_rd;
      o_avm_write      <= w_wr;
      o_avm_address    <= w_addr;
      o_busy           <= (w_next != S_IDLE);
      o_done           <= '0;
`ifdef DIVZERO_BYPASS_EN
      o_divzero        <= 1'b0;
`endif
      if (r_state == S_IDLE && w_found) begin
        r_id  <= w_grant;
        r_ptr <= w_grant;
      end
      // Read data arrives one cycle after the strobe
      if (r_state == S_RD_QUOT_W) r_qTmp <= i_avm_readdata;
      if (r_state == S_RD_REM_W)  r_rTmp <= i_avm_readdata;
      // Results are published only on entry to DONE so they stay stable
      // for the client until the next completion
      if (w_next == S_DONE) begin
`ifdef DIVZERO_BYPASS_EN
        if (w_bypass) begin
          o_done      <= {{(N-1){1'b0}}, 1'b1} << w_grant;
          o_resp_id   <= w_grant;
          o_quotient  <= '1;
          o_remainder <= w_grantDvnd;
          o_divzero   <= 1'b1;
        end else begin
          o_done      <= {{(N-1){1'b0}}, 1'b1} << r_id;
          o_resp_id   <= r_id;
          o_quotient  <= r_qTmp;
          o_remainder <= r_rTmp;
        end
`else
        o_done      <= {{(N-1){1'b0}}, 1'b1} << r_id;
        o_resp_id   <= r_id;
        o_quotient  <= r_qTmp;
        o_remainder <= r_rTmp;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_avalon_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for div_avalon_scheduler: a behavioural divider slave, a bus
// logger, table-driven single jobs, hand-written arbitration/reset/irq
// sequences and a randomized round-robin run against a reference model.
// -----------------------------------------------------------------------------
module tb_div_avalon_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] dvndFlat;
  logic [N*W-1:0] dvsrFlat;
  logic [N-1:0]   done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic [IDW-1:0] respId;
  logic           busy;
  logic           cs;
  logic           rd;
  logic           wr;
  logic [2:0]     addr;
  logic [W-1:0]   wdata;
  logic [W-1:0]   rdata;
  logic           irq;
`ifdef DIVZERO_BYPASS_EN
  logic           divzero;
`endif

  logic [W-1:0] opA [N];
  logic [W-1:0] opB [N];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  div_avalon_scheduler #(.N(N), .W(W), .IDW(IDW)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_req            (req),
    .i_dividend_flat  (dvndFlat),
    .i_divisor_flat   (dvsrFlat),
    .o_done           (done),
    .o_quotient       (quotient),
    .o_remainder      (remainder),
    .o_resp_id        (respId),
    .o_busy           (busy),
`ifdef DIVZERO_BYPASS_EN
    .o_divzero        (divzero),
`endif
    .o_avm_chipselect (cs),
    .o_avm_read       (rd),
    .o_avm_write      (wr),
    .o_avm_address    (addr),
    .o_avm_writedata  (wdata),
    .i_avm_readdata   (rdata),
    .i_div_irq        (irq)
  );

  // Pack per-client operands onto the flat buses
  always_comb begin
    dvndFlat = '0;
    dvsrFlat = '0;
    for (int i = 0; i < N; i++) begin
      dvndFlat[i*W +: W] = opA[i];
      dvsrFlat[i*W +: W] = opB[i];
    end
  end

  // Behavioural divider slave: registered reads (one wait state), irq
  // raised irqDelay+1 cycles after start, cleared by a write to address 6
  logic [W-1:0] sDvnd, sDvsr, sQ, sR;
  logic         sIrq, sPend;
  int           sCnt;
  int           irqDelay = 0;
  logic         irqForce = 1'b0;

  assign irq = sIrq | irqForce;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sDvnd <= '0; sDvsr <= '0; sQ <= '0; sR <= '0;
      sIrq <= 1'b0; sPend <= 1'b0; sCnt <= 0; rdata <= '0;
    end else begin
      if (sPend) begin
        if (sCnt == 0) begin
          sIrq  <= 1'b1;
          sPend <= 1'b0;
        end else begin
          sCnt <= sCnt - 1;
        end
      end
      if (cs && wr) begin
        case (addr)
          3'd0: sDvnd <= wdata;
          3'd1: sDvsr <= wdata;
          3'd2: begin
            sQ    <= (sDvsr == '0) ? '1 : sDvnd / sDvsr;
            sR    <= (sDvsr == '0) ? sDvnd : sDvnd % sDvsr;
            sPend <= 1'b1;
            sCnt  <= irqDelay;
          end
          3'd6: sIrq <= 1'b0;
          default: ;
        endcase
      end
      if (cs && rd) rdata <= (addr == 3'd3) ? sQ : (addr == 3'd4) ? sR : '0;
    end
  end

  // Bus access log, consumed per job
  typedef struct packed {
    logic         wr;
    logic [2:0]   addr;
    logic [W-1:0] data;
  } busT;
  busT busLog [$];

  always @(posedge clk) begin
    if (!reset && (rd || wr)) busLog.push_back({wr, addr, wdata});
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Chipselect must track the strobes, and read/write never overlap
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cs_vs_strobes", 64'(cs), 64'(rd | wr));
      checkOutput("rd_wr_exclusive", 64'(rd & wr), 64'd0);
    end
  end

  task automatic applyStimulus(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    opA[c] = a;
    opB[c] = b;
    req[c] = 1'b1;
  endtask

  // Wait (bounded) for a done pulse and check result plus the job's bus trace
  task automatic waitJob(input int expId, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expQ, input logic [W-1:0] expR, output int lat);
    logic [3:0]   kinds [6];
    logic [W-1:0] eData [3];
    int cyc = 0;
    kinds = '{4'h8, 4'h9, 4'hA, 4'h3, 4'h4, 4'hE};
    eData = '{a, b, {W{1'b0}}};
    lat = -1;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == '0 && cyc < 400);
    if (done == '0) begin
      checkOutput("done_timeout", 64'(done), 64'(1 << expId));
      return;
    end
    lat = cyc;
    checkOutput("done_vec", 64'(done), 64'(1 << expId));
    checkOutput("resp_id", 64'(respId), 64'(expId));
    checkOutput("quotient", 64'(quotient), 64'(expQ));
    checkOutput("remainder", 64'(remainder), 64'(expR));
    checkOutput("bus_count", 64'(busLog.size()), 64'd6);
    if (busLog.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        checkOutput("bus_kind", 64'({busLog[j].wr, busLog[j].addr}), 64'(kinds[j]));
        if (j < 3) checkOutput("bus_wdata", 64'(busLog[j].data), 64'(eData[j]));
      end
    end
    busLog.delete();
  endtask

  // The cycle after done: pulse gone, block idle
  task automatic afterDone();
    @(negedge clk);
    checkOutput("done_width", 64'(done), 64'd0);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    req      = '0;
    irqForce = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    busLog.delete();
  endtask

  typedef struct {
    int           client;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           delay;
  } vecT;

  initial begin
    vecT vecs [6];
    int  lat;
    int  rrPtr;
    int  expId;
    int  seq [6];
    vecs[0] = '{0, 100,          7,    14,           2, 0};
    vecs[1] = '{1, 50,           5,    10,           0, 1};
    vecs[2] = '{2, 9,            4,    2,            1, 3};
    vecs[3] = '{3, 32'hFFFF_FFFF, 1,   32'hFFFF_FFFF, 0, 0};
    vecs[4] = '{0, 7,            100,  0,            7, 2};
    vecs[5] = '{3, 1000,         1000, 1,            0, 4};
    seq = '{0, 1, 2, 3, 0, 1};

    for (int i = 0; i < N; i++) begin
      opA[i] = '0;
      opB[i] = 32'd1;
    end
    req   = '0;
    reset = 1'b1;
    #1;
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_quotient", 64'(quotient), 64'd0);
    checkOutput("rst_resp_id", 64'(respId), 64'd0);
    checkOutput("rst_strobes", 64'({cs, rd, wr, addr}), 64'd0);
    doReset();

    // Table of single-client jobs with varying irq latency
    for (int v = 0; v < 6; v++) begin
      irqDelay = vecs[v].delay;
      applyStimulus(vecs[v].client, vecs[v].a, vecs[v].b);
      waitJob(vecs[v].client, vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, lat);
      checkOutput("latency", 64'(lat), 64'(11 + vecs[v].delay));
      req[vecs[v].client] = 1'b0;
      afterDone();
      repeat (2) @(negedge clk);
      checkOutput("q_hold", 64'(quotient), 64'(vecs[v].q));
      checkOutput("r_hold", 64'(remainder), 64'(vecs[v].r));
    end

    // Simultaneous requests: client 0 first after reset, then client 1
    doReset();
    irqDelay = 0;
    applyStimulus(0, 50, 5);
    applyStimulus(1, 9, 4);
    waitJob(0, 50, 5, 10, 0, lat);
    req[0] = 1'b0;
    afterDone();
    waitJob(1, 9, 4, 2, 1, lat);
    req[1] = 1'b0;
    afterDone();

    // All four held for six jobs: order 0,1,2,3,0,1
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 32'(100 * (i + 1) + i), 32'(i + 3));
    for (int k = 0; k < 6; k++) begin
      expId = seq[k];
      waitJob(expId, opA[expId], opB[expId], opA[expId] / opB[expId], opA[expId] % opB[expId], lat);
      if (k == 5) req = '0;
      afterDone();
    end

    // Client 2 arrives during client 0's WAIT_IRQ and is served next
    doReset();
    irqDelay = 8;
    applyStimulus(0, 100, 7);
    repeat (6) @(negedge clk);
    checkOutput("busy_in_wait", 64'(busy), 64'd1);
    applyStimulus(2, 77, 8);
    waitJob(0, 100, 7, 14, 2, lat);
    req[0] = 1'b0;
    afterDone();
    irqDelay = 0;
    waitJob(2, 77, 8, 9, 5, lat);
    req[2] = 1'b0;
    afterDone();

    // irq high outside WAIT_IRQ is ignored; high on entry is taken at once
    doReset();
    irqForce = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("irq_idle_busy", 64'(busy), 64'd0);
    checkOutput("irq_idle_bus", 64'(busLog.size()), 64'd0);
    irqDelay = 0;
    applyStimulus(1, 12, 5);
    waitJob(1, 12, 5, 2, 2, lat);
    checkOutput("latency_irq_early", 64'(lat), 64'd10);
    req[1]   = 1'b0;
    irqForce = 1'b0;
    afterDone();

    // Reset in WAIT_IRQ: immediate idle outputs, no done, pointer reset
    doReset();
    irqDelay = 30;
    applyStimulus(0, 100, 7);
    repeat (6) @(negedge clk);
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_strobes", 64'({cs, rd, wr, addr}), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    applyStimulus(1, 30, 4);
    repeat (2) @(negedge clk);
    checkOutput("reset_no_done", 64'(done), 64'd0);
    busLog.delete();
    irqDelay = 0;
    reset    = 1'b0;
    waitJob(0, 100, 7, 14, 2, lat);
    checkOutput("latency_after_reset", 64'(lat), 64'd11);
    req[0] = 1'b0;
    afterDone();
    waitJob(1, 30, 4, 7, 2, lat);
    req[1] = 1'b0;
    afterDone();

    // Randomized traffic against a round-robin reference model
    doReset();
    rrPtr = N - 1;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1)
        applyStimulus(i, $urandom, ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : $urandom_range(1, 5000));
    end
    if (req == '0) applyStimulus(2, $urandom, $urandom_range(1, 5000));
    for (int job = 0; job < 20; job++) begin
      expId = -1;
      for (int k = 1; k <= N; k++) begin
        if (expId < 0 && req[(rrPtr + k) % N]) expId = (rrPtr + k) % N;
      end
      irqDelay = $urandom_range(0, 4);
      waitJob(expId, opA[expId], opB[expId], opA[expId] / opB[expId], opA[expId] % opB[expId], lat);
      checkOutput("rand_latency", 64'(lat), 64'(11 + irqDelay));
      rrPtr      = expId;
      req[expId] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1)
          applyStimulus(i, $urandom, ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : $urandom_range(1, 5000));
      end
      if (req == '0) applyStimulus(int'($urandom_range(0, N - 1)), $urandom, $urandom_range(1, 5000));
      if (job == 19) req = '0;
      afterDone();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div_avalon_scheduler.md
Name: div_avalon_scheduler

Overview:
- Avalon-MM master that shares one div_avalon integer divider between N client requesters.
- Arbitrates round-robin among pending requests and runs the divider register sequence for the winner: write dividend, write divisor, start, wait irq, read quotient, read remainder, clear irq.
- Returns the results to the winning client with a one-cycle done pulse.
- Sits between client logic and the divider's Avalon-MM slave port, replacing the scripted bus master used in simulation.

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, operand/result width; must equal divider W.
- IDW, 2, requester index width; ceil(log2(N)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  request per client; held high with operands stable until own done pulse.
- dividend_flat  in  N*W  client i dividend at [i*W +: W].
- divisor_flat  in  N*W  client i divisor at [i*W +: W].
- done  out  N  one-cycle pulse to finished client.
- quotient  out  W  result quotient, valid during done pulse.
- remainder  out  W  result remainder, valid during done pulse.
- resp_id  out  IDW  index of client served, valid during done pulse.
- busy  out  1  high from grant until done pulse.
- avm_chipselect  out  1  divider chipselect.
- avm_read  out  1  divider read strobe.
- avm_write  out  1  divider write strobe.
- avm_address  out  3  divider register address.
- avm_writedata  out  W  divider write data.
- avm_readdata  in  W  divider read data.
- div_irq  in  1  divider done interrupt.

Behaviour:
- Divider register map:
  - 0 dividend (W)
  - 1 divisor (W)
  - 2 start (write, any data)
  - 3 quotient (R)
  - 4 remainder (R)
  - 6 irq clear (write).
- Reads have one wait state: avm_readdata is sampled on the clock edge after the read strobe cycle.
- Reset (async): state IDLE; all outputs 0; rr pointer = N-1, so client 0 has first priority.
- Strobes are registered; chipselect is high exactly when read or write is high; each access lasts one cycle.
- FSM, one state per cycle unless noted:
  - IDLE: if any req, grant = first set bit searching from ptr+1 mod N; latch id; ptr<=id; busy<=1; go WR_DVND. Otherwise stay.
  - WR_DVND: write addr0 with the latched client's dividend.
  - WR_DVSR: write addr1 with its divisor.
  - WR_START: write addr2, data 0.
  - WAIT_IRQ: bus idle until div_irq=1; unbounded.
  - RD_QUOT: read addr3. Next cycle (RD_QUOT_W) capture quotient.
  - RD_REM: read addr4. Next cycle (RD_REM_W) capture remainder.
  - CLR_IRQ: write addr6.
  - DONE: done[id]=1, resp_id=id, busy<=0; then IDLE.
- Operands are sampled from the flat buses in WR_DVND/WR_DVSR; no internal copy.
- Minimum grant-to-done latency: 9 cycles + WAIT_IRQ time.
- A new grant is possible the cycle after DONE.
- quotient/remainder/resp_id hold their values until the next DONE.
- A request asserted during busy waits; arbitration occurs only in IDLE.
- req dropping after grant: the job still completes and the done pulse is still issued.
- div_irq already high on entering WAIT_IRQ is accepted immediately (one cycle in WAIT_IRQ).
- div_irq in any other state is ignored.
- reset mid-job: immediate return to IDLE; no done pulse; pointer reset. The divider shares the same reset.

Optional Feature:
- Macro DIVZERO_BYPASS_EN.
- Defined: in IDLE, a granted job with divisor==0 skips the divider. Next cycle is DONE with quotient = all ones, remainder = dividend, and output divzero (1 bit, pulse aligned with done) = 1. No bus traffic.
- Undefined: no divzero port; zero divisors go to the divider like any other job; the result is whatever the divider returns.

Test Plan:
- Single job: client 0 req with 100/7 -> bus writes addr0=0x64, addr1=0x7, addr2; after irq reads addr3, addr4; write addr6; done=0001, quotient=14, remainder=2, resp_id=0.
- Simultaneous req=0011 (client 0: 50/5, client 1: 9/4) -> client 0 served first (q=10, r=0), then client 1 (q=2, r=1); done pulses in that order.
- All four req held continuously for 6 jobs -> grant order 0,1,2,3,0,1; each done pulse is exactly one cycle.
- Client 2 asserts req during client 0's WAIT_IRQ -> no bus activity for client 2 until after client 0's DONE; served next.
- Reset asserted in WAIT_IRQ -> outputs 0 the same cycle; no done pulse. After release, client 0 100/7 completes normally.
- DIVZERO_BYPASS_EN: client 3 with 0x1234/0 -> no avm strobes; done=1000 two cycles after req; quotient=0xFFFFFFFF, remainder=0x1234, divzero=1.
